// File: rtl/id_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
// One scoreboard slot is one in-flight register write.
package id_pkg;

  localparam int SB_RA_W  = 5;
  localparam int SB_LAT_W = 2;

  localparam int FWD_RF   = 0;
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  typedef struct packed {
    logic                valid;
    logic                fp;
    logic [SB_RA_W-1:0]  rw;
    logic [SB_LAT_W-1:0] rdy;
  } sb_entry_t;

endpackage

// File: rtl/sb_operand_match.sv
// Youngest-match search of one source operand against all slots.
// Array index j holds pipeline slot j+1.
module sb_operand_match
  import id_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int RA_W  = 5,
  parameter int SEL_W = 2
) (
  input  logic             use_i,
  input  logic             fp_i,
  input  logic [RA_W-1:0]  ra_i,
  input  sb_entry_t        slot_i [DEPTH],
  output logic             hit_o,
  output logic [SEL_W-1:0] k_o,
  output logic             ready_o
);

  logic live;

  // Walk oldest to youngest so the youngest match is the last one kept.
  // GPR r0 is hardwired zero and never matches; FPR f0 is real.
  always_comb begin
    hit_o   = 1'b0;
    k_o     = '0;
    ready_o = 1'b1;
    live    = use_i & (fp_i | (ra_i != '0));
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (live && slot_i[j].valid &&
          slot_i[j].fp == fp_i &&
          slot_i[j].rw == ra_i) begin
        hit_o   = 1'b1;
        k_o     = SEL_W'(j + 1);
        ready_o = (j + 1) >= int'(slot_i[j].rdy);
      end
    end
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage scoreboard: DEPTH-slot shift of in-flight writes, stall and forwarding selects.
// Optional stall statistics counter enabled by SCOREBOARD_STATS_EN.
module id_hazard_scoreboard
  import id_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int RA_W  = 5,
  parameter int LAT_W = 2,
  parameter int SEL_W = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue_valid,
  input  logic                         issue_we,
  input  logic                         issue_fp,
  input  logic [RA_W-1:0]              issue_rw,
  input  logic [LAT_W-1:0]             issue_rdy,
  input  logic [RA_W-1:0]              rs,
  input  logic [RA_W-1:0]              rt,
  input  logic                         rs_fp,
  input  logic                         rt_fp,
  input  logic                         use_rs,
  input  logic                         use_rt,
  input  logic                         flush,
  output logic                         stall,
  output logic [SEL_W-1:0]             op_a_sel,
  output logic [SEL_W-1:0]             op_b_sel,
`ifdef SCOREBOARD_STATS_EN
  output logic [31:0]                  stall_cycles,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   inflight
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  sb_entry_t        slot_q [DEPTH];
  sb_entry_t        slot_d [DEPTH];
  logic             a_hit, a_rdy;
  logic             b_hit, b_rdy;
  logic [SEL_W-1:0] a_k, b_k;

  sb_operand_match #(
    .DEPTH (DEPTH),
    .RA_W  (RA_W),
    .SEL_W (SEL_W)
  ) u_match_rs (
    .use_i   (use_rs),
    .fp_i    (rs_fp),
    .ra_i    (rs),
    .slot_i  (slot_q),
    .hit_o   (a_hit),
    .k_o     (a_k),
    .ready_o (a_rdy)
  );

  sb_operand_match #(
    .DEPTH (DEPTH),
    .RA_W  (RA_W),
    .SEL_W (SEL_W)
  ) u_match_rt (
    .use_i   (use_rt),
    .fp_i    (rt_fp),
    .ra_i    (rt),
    .slot_i  (slot_q),
    .hit_o   (b_hit),
    .k_o     (b_k),
    .ready_o (b_rdy)
  );

  // A hit that is not yet ready holds ID; its sel is still driven as k.
  always_comb begin
    stall    = issue_valid & ~flush &
               ((a_hit & ~a_rdy) | (b_hit & ~b_rdy));
    op_a_sel = a_hit ? a_k : SEL_W'(FWD_RF);
    op_b_sel = b_hit ? b_k : SEL_W'(FWD_RF);
  end

  // Next slot contents: new entry or bubble in slot 1, flush kills old slot 1.
  always_comb begin
    slot_d[0] = '0;
    if (issue_valid & issue_we & ~stall & ~flush) begin
      slot_d[0].valid = 1'b1;
      slot_d[0].fp    = issue_fp;
      slot_d[0].rw    = issue_rw;
      slot_d[0].rdy   = (issue_rdy == '0) ? LAT_W'(LAT_ALU)
                                          : issue_rdy;
    end
    for (int j = 1; j < DEPTH; j++) begin
      slot_d[j] = slot_q[j-1];
    end
    slot_d[1].valid = slot_q[0].valid & ~flush;
  end

  // Slot shift register; the last slot retires every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        slot_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        slot_q[j] <= slot_d[j];
      end
    end
  end

  // Population count of valid slots.
  always_comb begin
    inflight = '0;
    for (int j = 0; j < DEPTH; j++) begin
      inflight = inflight + CNT_W'(slot_q[j].valid);
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Self-checking bench for id_hazard_scoreboard (stall_cycles checked when SCOREBOARD_STATS_EN).
// Expected outputs are queued as each cycle is driven and popped at the negedge.
module tb_id_hazard_scoreboard;
  import id_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, issue_we, issue_fp;
  logic [4:0] issue_rw;
  logic [1:0] issue_rdy;
  logic [4:0] rs, rt;
  logic       rs_fp, rt_fp, use_rs, use_rt, flush;
  logic       stall;
  logic [1:0] op_a_sel, op_b_sel;
  logic [1:0] inflight;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
`endif

  id_hazard_scoreboard #(
    .DEPTH (3),
    .RA_W  (5),
    .LAT_W (2),
    .SEL_W (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_we     (issue_we),
    .issue_fp     (issue_fp),
    .issue_rw     (issue_rw),
    .issue_rdy    (issue_rdy),
    .rs           (rs),
    .rt           (rt),
    .rs_fp        (rs_fp),
    .rt_fp        (rt_fp),
    .use_rs       (use_rs),
    .use_rt       (use_rt),
    .flush        (flush),
    .stall        (stall),
    .op_a_sel     (op_a_sel),
    .op_b_sel     (op_b_sel),
`ifdef SCOREBOARD_STATS_EN
    .stall_cycles (stall_cycles),
`endif
    .inflight     (inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v, we, fp;
    logic [4:0] rw;
    logic [1:0] rdy;
    logic [4:0] rs, rt;
    logic       rsf, rtf, urs, urt, fl;
  } stim_t;

  typedef struct {
    logic       st;
    logic [1:0] a, b, inf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_model = 0;

  function automatic stim_t mk(logic v, logic we, logic fp,
                               int rw, int rdy,
                               int rsa, logic rsf, logic urs,
                               int rta, logic rtf, logic urt,
                               logic fl);
    stim_t s;
    s.v = v; s.we = we; s.fp = fp;
    s.rw = 5'(rw); s.rdy = 2'(rdy);
    s.rs = 5'(rsa); s.rsf = rsf; s.urs = urs;
    s.rt = 5'(rta); s.rtf = rtf; s.urt = urt;
    s.fl = fl;
    return s;
  endfunction

  function automatic stim_t wr(logic fp, int rw, int rdy);
    return mk(1, 1, fp, rw, rdy, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic stim_t rd(int rsa, logic rsf, int rta, logic rtf);
    return mk(1, 0, 0, 0, 0, rsa, rsf, 1, rta, rtf, 1, 0);
  endfunction

  function automatic stim_t wrd(int rw, int rdy, int rsa, logic rsf,
                                int rta, logic rtf);
    return mk(1, 1, 0, rw, rdy, rsa, rsf, 1, rta, rtf, 1, 0);
  endfunction

  function automatic stim_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic exp_t ex(logic st, int a, int b, int inf);
    exp_t e;
    e.st = st; e.a = 2'(a); e.b = 2'(b); e.inf = 2'(inf);
    return e;
  endfunction

  task automatic drive(input stim_t s);
    issue_valid = s.v;  issue_we  = s.we;
    issue_fp    = s.fp; issue_rw  = s.rw;
    issue_rdy   = s.rdy;
    rs = s.rs; rs_fp = s.rsf; use_rs = s.urs;
    rt = s.rt; rt_fp = s.rtf; use_rt = s.urt;
    flush = s.fl;
  endtask

  task automatic test_reset();
    stim_t s[$];
    exp_t  e[$];
    exp_t  x;
    reset = 1'b1;
    drive(nop());
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_init stall got %b exp 0", stall); end
    if (op_a_sel !== 2'd0) begin errors++; $display("FAIL reset_init sel_a got %0d exp 0", op_a_sel); end
    if (op_b_sel !== 2'd0) begin errors++; $display("FAIL reset_init sel_b got %0d exp 0", op_b_sel); end
    if (inflight !== 2'd0) begin errors++; $display("FAIL reset_init inflight got %0d exp 0", inflight); end
`ifdef SCOREBOARD_STATS_EN
    checks++;
    if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_init stall_cycles got %0d exp 0", stall_cycles); end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    s = '{wr(0, 1, 1), wr(0, 2, 1), wr(0, 3, 1)};
    e = '{ex(0, 0, 0, 0), ex(0, 0, 0, 1), ex(0, 0, 0, 2)};
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      x = exp_q.pop_front();
      checks += 4;
      if (stall !== x.st) begin errors++; $display("FAIL reset_fill c%0d stall got %b exp %b", i, stall, x.st); end
      if (op_a_sel !== x.a) begin errors++; $display("FAIL reset_fill c%0d sel_a got %0d exp %0d", i, op_a_sel, x.a); end
      if (op_b_sel !== x.b) begin errors++; $display("FAIL reset_fill c%0d sel_b got %0d exp %0d", i, op_b_sel, x.b); end
      if (inflight !== x.inf) begin errors++; $display("FAIL reset_fill c%0d inflight got %0d exp %0d", i, inflight, x.inf); end
      @(posedge clk); #1;
    end
    drive(rd(3, 0, 1, 0));
    #1;
    checks += 3;
    if (inflight !== 2'd3) begin errors++; $display("FAIL reset_full inflight got %0d exp 3", inflight); end
    if (op_a_sel !== 2'd1) begin errors++; $display("FAIL reset_full sel_a got %0d exp 1", op_a_sel); end
    if (op_b_sel !== 2'd3) begin errors++; $display("FAIL reset_full sel_b got %0d exp 3", op_b_sel); end
    reset = 1'b1;
    #1;
    checks += 4;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_async stall got %b exp 0", stall); end
    if (op_a_sel !== 2'd0) begin errors++; $display("FAIL reset_async sel_a got %0d exp 0", op_a_sel); end
    if (op_b_sel !== 2'd0) begin errors++; $display("FAIL reset_async sel_b got %0d exp 0", op_b_sel); end
    if (inflight !== 2'd0) begin errors++; $display("FAIL reset_async inflight got %0d exp 0", inflight); end
    @(posedge clk); #1;
    reset = 1'b0;
    stall_model = 0;
    drive(nop());
  endtask

  task automatic test_alu_chain();
    stim_t s[$];
    exp_t  e[$];
    exp_t  x;
    s = '{wr(0, 3, LAT_ALU), wrd(4, LAT_ALU, 3, 0, 3, 0),
          rd(3, 0, 4, 0), mk(0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 1, 0),
          nop()};
    e = '{ex(0, 0, 0, 0), ex(0, 1, 1, 1), ex(0, 2, 1, 2),
          ex(0, 3, 0, 2), ex(0, 0, 0, 1)};
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      if (e[i].st) stall_model++;
      @(negedge clk);
      x = exp_q.pop_front();
      checks += 4;
      if (stall !== x.st) begin errors++; $display("FAIL alu c%0d stall got %b exp %b", i, stall, x.st); end
      if (op_a_sel !== x.a) begin errors++; $display("FAIL alu c%0d sel_a got %0d exp %0d", i, op_a_sel, x.a); end
      if (op_b_sel !== x.b) begin errors++; $display("FAIL alu c%0d sel_b got %0d exp %0d", i, op_b_sel, x.b); end
      if (inflight !== x.inf) begin errors++; $display("FAIL alu c%0d inflight got %0d exp %0d", i, inflight, x.inf); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t s[$];
    exp_t  e[$];
    exp_t  x;
    s = '{wr(0, 5, LAT_LOAD), wrd(6, 1, 5, 0, 9, 0),
          wrd(6, 1, 5, 0, 9, 0), rd(6, 0, 5, 0), nop(), nop()};
    e = '{ex(0, 0, 0, 0), ex(1, 1, 0, 1), ex(0, 2, 0, 1),
          ex(0, 1, 3, 2), ex(0, 0, 0, 1), ex(0, 0, 0, 1)};
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      if (e[i].st) stall_model++;
      @(negedge clk);
      x = exp_q.pop_front();
      checks += 4;
      if (stall !== x.st) begin errors++; $display("FAIL load c%0d stall got %b exp %b", i, stall, x.st); end
      if (op_a_sel !== x.a) begin errors++; $display("FAIL load c%0d sel_a got %0d exp %0d", i, op_a_sel, x.a); end
      if (op_b_sel !== x.b) begin errors++; $display("FAIL load c%0d sel_b got %0d exp %0d", i, op_b_sel, x.b); end
      if (inflight !== x.inf) begin errors++; $display("FAIL load c%0d inflight got %0d exp %0d", i, inflight, x.inf); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fpu();
    stim_t s[$];
    exp_t  e[$];
    exp_t  x;
    stim_t c;
    c = mk(1, 1, 0, 8, 1, 2, 1, 1, 2, 0, 1, 0);
    s = '{wr(1, 2, 3), c, c, c, nop(), nop(), nop()};
    e = '{ex(0, 0, 0, 0), ex(1, 1, 0, 1), ex(1, 2, 0, 1),
          ex(0, 3, 0, 1), ex(0, 0, 0, 1), ex(0, 0, 0, 1),
          ex(0, 0, 0, 1)};
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      if (e[i].st) stall_model++;
      @(negedge clk);
      x = exp_q.pop_front();
      checks += 4;
      if (stall !== x.st) begin errors++; $display("FAIL fpu c%0d stall got %b exp %b", i, stall, x.st); end
      if (op_a_sel !== x.a) begin errors++; $display("FAIL fpu c%0d sel_a got %0d exp %0d", i, op_a_sel, x.a); end
      if (op_b_sel !== x.b) begin errors++; $display("FAIL fpu c%0d sel_b got %0d exp %0d", i, op_b_sel, x.b); end
      if (inflight !== x.inf) begin errors++; $display("FAIL fpu c%0d inflight got %0d exp %0d", i, inflight, x.inf); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_r0_shadow();
    stim_t s[$];
    exp_t  e[$];
    exp_t  x;
    s = '{wr(0, 0, 1), rd(0, 0, 0, 0), wr(0, 7, 3), wr(0, 7, 0),
          rd(7, 0, 7, 0), nop(), nop()};
    e = '{ex(0, 0, 0, 0), ex(0, 0, 0, 1), ex(0, 0, 0, 1),
          ex(0, 0, 0, 2), ex(0, 1, 1, 2), ex(0, 0, 0, 2),
          ex(0, 0, 0, 1)};
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      if (e[i].st) stall_model++;
      @(negedge clk);
      x = exp_q.pop_front();
      checks += 4;
      if (stall !== x.st) begin errors++; $display("FAIL r0shadow c%0d stall got %b exp %b", i, stall, x.st); end
      if (op_a_sel !== x.a) begin errors++; $display("FAIL r0shadow c%0d sel_a got %0d exp %0d", i, op_a_sel, x.a); end
      if (op_b_sel !== x.b) begin errors++; $display("FAIL r0shadow c%0d sel_b got %0d exp %0d", i, op_b_sel, x.b); end
      if (inflight !== x.inf) begin errors++; $display("FAIL r0shadow c%0d inflight got %0d exp %0d", i, inflight, x.inf); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    stim_t s[$];
    exp_t  e[$];
    exp_t  x;
    stim_t fl_ld, fl_use;
    fl_ld  = wr(0, 6, LAT_LOAD);
    fl_ld.fl = 1'b1;
    fl_use = rd(6, 0, 0, 0);
    fl_use.fl = 1'b1;
    s = '{fl_ld, rd(6, 0, 0, 0), wr(0, 6, LAT_LOAD), fl_use,
          rd(6, 0, 0, 0)};
    e = '{ex(0, 0, 0, 0), ex(0, 0, 0, 0), ex(0, 0, 0, 0),
          ex(0, 1, 0, 1), ex(0, 0, 0, 0)};
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      if (e[i].st) stall_model++;
      @(negedge clk);
      x = exp_q.pop_front();
      checks += 4;
      if (stall !== x.st) begin errors++; $display("FAIL flush c%0d stall got %b exp %b", i, stall, x.st); end
      if (op_a_sel !== x.a) begin errors++; $display("FAIL flush c%0d sel_a got %0d exp %0d", i, op_a_sel, x.a); end
      if (op_b_sel !== x.b) begin errors++; $display("FAIL flush c%0d sel_b got %0d exp %0d", i, op_b_sel, x.b); end
      if (inflight !== x.inf) begin errors++; $display("FAIL flush c%0d inflight got %0d exp %0d", i, inflight, x.inf); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stats();
`ifdef SCOREBOARD_STATS_EN
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'(stall_model)) begin
      errors++;
      $display("FAIL stats stall_cycles got %0d exp %0d", stall_cycles, stall_model);
    end
`endif
  endtask

  task automatic settle();
    drive(nop());
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    settle();
    test_alu_chain();
    settle();
    test_load_use();
    settle();
    test_fpu();
    settle();
    test_r0_shadow();
    settle();
    test_flush();
    settle();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
